// File: rtl/rtdf_sample_packer_if.sv
// Sample-in / word-out stream bundle for the real-time sample packer.
interface rtdf_sample_packer_if;
    localparam int unsigned SAMPLE_W = 3;
    localparam int unsigned WORD_W   = 16;

    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic                word_valid;
    logic [WORD_W-1:0]   word_data;
    logic                word_ready;

    // Packer side: consumes samples, produces words
    modport master (
        input  sample_valid,
        input  sample_data,
        input  word_ready,
        output word_valid,
        output word_data
    );

    // Environment side: produces samples, consumes words
    modport slave (
        output sample_valid,
        output sample_data,
        output word_ready,
        input  word_valid,
        input  word_data
    );
endinterface

// File: rtl/rtdf_sample_packer.sv
// Packs 3b samples LSB-first into 16b words and queues them in a small FWFT FIFO.
module rtdf_sample_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk_sample,
    input  logic                    reset_n,
    rtdf_sample_packer_if.master    bus,
    input  logic                    flush,
    input  logic                    clear_stats,
    output logic [FIFO_AW:0]        fill_level,
    output logic [3:0]              bit_phase,
    output logic                    flush_busy,
    output logic [CNT_WIDTH-1:0]    word_count,
    output logic [CNT_WIDTH-1:0]    drop_count,
    output logic                    overflow
);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ACC_W  = 18;

    typedef enum logic [0:0] {ST_RUN, ST_PAD} state_e;
    typedef logic [FIFO_AW-1:0]   ptr_t;
    typedef logic [FIFO_AW:0]     lvl_t;
    typedef logic [CNT_WIDTH-1:0] stat_t;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [3:0]          nbits_q, nbits_d;
    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    ptr_t                wr_ptr_q, wr_ptr_d;
    ptr_t                rd_ptr_q, rd_ptr_d;
    lvl_t                cnt_q, cnt_d;
    stat_t               word_cnt_q, word_cnt_d;
    stat_t               drop_cnt_q, drop_cnt_d;
    logic                ovf_q, ovf_d;

    logic [ACC_W-1:0]    acc_new, acc_sel;
    logic [4:0]          t;
    logic                push, pop, full, accept, drop;
    logic [WORD_W-1:0]   push_word;

    // Packing FSM: accumulate bits, emit full words, handle flush padding
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        nbits_d   = nbits_q;
        push      = 1'b0;
        push_word = '0;
        acc_new   = acc_q | (ACC_W'(bus.sample_data) << nbits_q);
        acc_sel   = bus.sample_valid ? acc_new : acc_q;
        t         = 5'(nbits_q) + (bus.sample_valid ? 5'd3 : 5'd0);
        case (state_q)
            ST_RUN: begin
                if (t >= 5'd16) begin
                    push      = 1'b1;
                    push_word = acc_sel[WORD_W-1:0];
                    acc_d     = acc_sel >> WORD_W;
                    nbits_d   = 4'(t - 5'd16);
                    // Leftover bits under flush still need their own padded word
                    if (flush && (t > 5'd16)) state_d = ST_PAD;
                end else if (flush && (t != 5'd0)) begin
                    push      = 1'b1;
                    push_word = acc_sel[WORD_W-1:0];
                    acc_d     = '0;
                    nbits_d   = '0;
                end else begin
                    acc_d   = acc_sel;
                    nbits_d = 4'(t);
                end
            end
            ST_PAD: begin
                push      = 1'b1;
                push_word = acc_q[WORD_W-1:0];
                state_d   = ST_RUN;
                acc_d     = bus.sample_valid ? ACC_W'(bus.sample_data) : '0;
                nbits_d   = bus.sample_valid ? 4'd3 : 4'd0;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FIFO bookkeeping and saturating statistics
    always_comb begin
        pop      = (cnt_q != '0) && bus.word_ready;
        full     = (cnt_q == lvl_t'(FIFO_DEPTH));
        accept   = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = accept ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        cnt_d    = cnt_q + lvl_t'(accept) - lvl_t'(pop);
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q | drop;
        if (accept && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + stat_t'(1);
        if (drop && (drop_cnt_q != '1))   drop_cnt_d = drop_cnt_q + stat_t'(1);
        if (clear_stats) begin
            word_cnt_d = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end
    end

    // State, accumulator, FIFO storage and counters
    always_ff @(posedge clk_sample or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            acc_q      <= '0;
            nbits_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            nbits_q    <= nbits_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
            if (accept) mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign bus.word_valid = (cnt_q != '0);
    assign bus.word_data  = mem_q[rd_ptr_q];
    assign fill_level     = cnt_q;
    assign bit_phase      = nbits_q;
    assign flush_busy     = (state_q == ST_PAD);
    assign word_count     = word_cnt_q;
    assign drop_count     = drop_cnt_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_rtdf_sample_packer.sv
// Self-checking bench for rtdf_sample_packer: vector table, directed corners, random vs bit-queue model.
module tb_rtdf_sample_packer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush, clear_stats;
    logic [2:0]  fill_level;
    logic [3:0]  bit_phase;
    logic        flush_busy;
    logic [15:0] word_count, drop_count;
    logic        overflow;

    rtdf_sample_packer_if bus ();

    rtdf_sample_packer #(.FIFO_DEPTH(4), .FIFO_AW(2), .CNT_WIDTH(16)) dut (
        .clk_sample  (clk),
        .reset_n     (reset_n),
        .bus         (bus.master),
        .flush       (flush),
        .clear_stats (clear_stats),
        .fill_level  (fill_level),
        .bit_phase   (bit_phase),
        .flush_busy  (flush_busy),
        .word_count  (word_count),
        .drop_count  (drop_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain bitstream queue plus a word queue
    bit          bitq[$];
    logic [15:0] fq[$];
    bit          m_pad;
    logic [15:0] m_wc, m_dc;
    bit          m_ovf;

    typedef struct {
        logic        v;
        logic [2:0]  d;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_data;
        logic [2:0]  e_fill;
        logic [3:0]  e_phase;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        bitq.delete();
        fq.delete();
        m_pad = 0;
        m_wc  = '0;
        m_dc  = '0;
        m_ovf = 0;
    endfunction

    // Takes up to 16 bits from the front of the stream, zero above
    function automatic logic [15:0] take_word();
        logic [15:0] w = '0;
        for (int k = 0; k < 16; k++)
            if (bitq.size() > 0) w[k] = bitq.pop_front();
        return w;
    endfunction

    function automatic void model_step(input logic v, input logic [2:0] d, input logic fl,
                                       input logic clr, input logic rdy);
        logic [15:0] w = '0;
        bit have = 0;
        bit pop;
        int sz;
        pop = (fq.size() > 0) && rdy;
        if (m_pad) begin
            w = take_word();
            have = 1;
            m_pad = 0;
            if (v) for (int k = 0; k < 3; k++) bitq.push_back(d[k]);
        end else begin
            if (v) for (int k = 0; k < 3; k++) bitq.push_back(d[k]);
            if (bitq.size() >= 16) begin
                w = take_word();
                have = 1;
                if (fl && bitq.size() > 0) m_pad = 1;
            end else if (fl && bitq.size() > 0) begin
                w = take_word();
                have = 1;
            end
        end
        sz = fq.size();
        if (pop) void'(fq.pop_front());
        if (have) begin
            if (sz < DEPTH || pop) begin
                fq.push_back(w);
                if (m_wc != 16'hFFFF) m_wc++;
            end else begin
                if (m_dc != 16'hFFFF) m_dc++;
                m_ovf = 1;
            end
        end
        if (clr) begin
            m_wc = '0;
            m_dc = '0;
            m_ovf = 0;
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".word_valid"}, bus.word_valid, (fq.size() > 0));
        if (fq.size() > 0) chk({tag, ".word_data"}, bus.word_data, fq[0]);
        chk({tag, ".fill_level"}, fill_level, fq.size());
        chk({tag, ".bit_phase"}, bit_phase, bitq.size());
        chk({tag, ".flush_busy"}, flush_busy, m_pad);
        chk({tag, ".word_count"}, word_count, m_wc);
        chk({tag, ".drop_count"}, drop_count, m_dc);
        chk({tag, ".overflow"}, overflow, m_ovf);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cycle(input logic v, input logic [2:0] d, input logic fl,
                         input logic clr, input logic rdy, input string tag);
        bus.sample_valid = v;
        bus.sample_data  = d;
        flush            = fl;
        clear_stats      = clr;
        bus.word_ready   = rdy;
        @(posedge clk);
        model_step(v, d, fl, clr, rdy);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic drain_expect(input string tag, input logic [15:0] exp);
        chk({tag, ".head_valid"}, bus.word_valid, 1'b1);
        chk({tag, ".head_data"}, bus.word_data, exp);
        cycle(0, 3'd0, 0, 0, 1, tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".word_valid"}, bus.word_valid, 0);
        chk({tag, ".word_data"}, bus.word_data, 0);
        chk({tag, ".fill_level"}, fill_level, 0);
        chk({tag, ".bit_phase"}, bit_phase, 0);
        chk({tag, ".flush_busy"}, flush_busy, 0);
        chk({tag, ".word_count"}, word_count, 0);
        chk({tag, ".drop_count"}, drop_count, 0);
        chk({tag, ".overflow"}, overflow, 0);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].v, tbl[i].d, 0, 0, tbl[i].rdy, tag);
            chk($sformatf("%s.row%0d.valid", tag, i), bus.word_valid, tbl[i].e_valid);
            if (tbl[i].e_valid)
                chk($sformatf("%s.row%0d.data", tag, i), bus.word_data, tbl[i].e_data);
            chk($sformatf("%s.row%0d.fill", tag, i), fill_level, tbl[i].e_fill);
            chk($sformatf("%s.row%0d.phase", tag, i), bit_phase, tbl[i].e_phase);
        end
        chk({tag, ".word_count"}, word_count, 3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ph[16] = '{3, 6, 9, 12, 15, 2, 5, 8, 11, 14, 1, 4, 7, 10, 13, 0};

        // Test 1 vectors: s_i = i%8 with ready held high
        for (int i = 0; i < 16; i++) begin
            tbl[i].v       = 1'b1;
            tbl[i].d       = 3'(i % 8);
            tbl[i].rdy     = 1'b1;
            tbl[i].e_valid = (i == 5) || (i == 10) || (i == 15);
            tbl[i].e_data  = (i == 5) ? 16'hC688 : (i == 10) ? 16'h88FA : 16'hFAC6;
            tbl[i].e_fill  = tbl[i].e_valid ? 3'd1 : 3'd0;
            tbl[i].e_phase = 4'(ph[i]);
        end
        tbl[16] = '{v: 1'b0, d: 3'd0, rdy: 1'b1, e_valid: 1'b0, e_data: 16'h0, e_fill: 3'd0, e_phase: 4'd0};

        reset_n          = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = 3'd0;
        bus.word_ready   = 1'b0;
        flush            = 1'b0;
        clear_stats      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_all_zero("reset");

        run_table("t1");

        // 16 all-ones samples -> three 0xFFFF words, phase back to 0
        for (int i = 0; i < 16; i++) cycle(1, 3'd7, 0, 0, 0, "t2");
        chk("t2.phase", bit_phase, 0);
        chk("t2.fill", fill_level, 3);
        for (int i = 0; i < 3; i++) drain_expect("t2.drain", 16'hFFFF);

        // Flush on an idle cycle
        for (int i = 0; i < 6; i++) cycle(1, 3'd7, 0, 0, 0, "t3a");
        chk("t3a.phase_pre", bit_phase, 2);
        cycle(0, 3'd0, 1, 0, 0, "t3a.flush");
        chk("t3a.phase_post", bit_phase, 0);
        chk("t3a.fill", fill_level, 2);
        drain_expect("t3a.w0", 16'hFFFF);
        drain_expect("t3a.w1", 16'h0003);

        // Flush coincident with the word-completing sample
        for (int i = 0; i < 5; i++) cycle(1, 3'd7, 0, 0, 0, "t3b");
        cycle(1, 3'd7, 1, 0, 0, "t3b.flush");
        chk("t3b.busy_set", flush_busy, 1);
        chk("t3b.phase_pad", bit_phase, 2);
        cycle(1, 3'd5, 1, 0, 0, "t3b.pad");
        chk("t3b.busy_clr", flush_busy, 0);
        chk("t3b.fill", fill_level, 2);
        chk("t3b.phase_next", bit_phase, 3);
        drain_expect("t3b.w0", 16'hFFFF);
        drain_expect("t3b.w1", 16'h0003);
        cycle(0, 3'd0, 1, 0, 0, "t3b.flush2");
        drain_expect("t3b.w2", 16'h0005);

        // Overflow with consumer stalled, then clear_stats
        cycle(0, 3'd0, 0, 1, 0, "t4.clr0");
        for (int i = 0; i < 32; i++) cycle(1, 3'($urandom_range(0, 7)), 0, 0, 0, "t4");
        chk("t4.fill", fill_level, 4);
        chk("t4.drop", drop_count, 2);
        chk("t4.ovf", overflow, 1);
        chk("t4.wcnt", word_count, 4);
        cycle(0, 3'd0, 0, 1, 0, "t4.clr");
        chk("t4.clr.drop", drop_count, 0);
        chk("t4.clr.ovf", overflow, 0);
        chk("t4.clr.wcnt", word_count, 0);
        chk("t4.clr.fill", fill_level, 4);

        // Full FIFO: push and pop in the same cycle
        for (int i = 0; i < 5; i++) cycle(1, 3'd1, 0, 0, 0, "t5");
        cycle(1, 3'd1, 0, 0, 1, "t5.pushpop");
        chk("t5.fill", fill_level, 4);
        chk("t5.drop", drop_count, 0);
        chk("t5.wcnt", word_count, 1);

        // Asynchronous reset mid-word
        for (int i = 0; i < 4; i++) cycle(1, 3'd6, 0, 0, 0, "t6");
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("t6.async");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        run_table("t6.t1");

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) < 6), "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
